bram_dp: RTL and testbench

//  Parametrised true-dual-port block RAM; successor to the single-port 32x1024 RAM.

---
 rtl/bram_port_if.sv | 26 ++
 rtl/bram_dp.sv | 117 +++++++++++
 tb/tb_bram_dp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_if.sv
// One access port of the dual-port RAM: request fields plus registered read return.
interface bram_port_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned NB = DATA_W / 8;

    logic              en;
    logic [NB-1:0]     we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    // Requester side: drives the access, receives read data
    modport master (
        output en, we, addr, wdata,
        input  rdata, rvalid
    );

    // Memory side: receives the access, returns read data
    modport slave (
        input  en, we, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/bram_dp.sv
// True-dual-port block RAM with byte enables, 1- or 2-cycle read latency and
// selectable same-port read-during-write behaviour. Cross-port reads see the old word.
module bram_dp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 1,
    parameter string       RDW_MODE = "READ_FIRST"
) (
    input  logic       clk,
    input  logic       rst,
    bram_port_if.slave a_io,
    bram_port_if.slave b_io
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          WF    = (RDW_MODE == "WRITE_FIRST");
    localparam bit          NC    = (RDW_MODE == "NO_CHANGE");

    // Reject unsupported configurations at elaboration
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("bram_dp: DATA_W must be a multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $error("bram_dp: READ_LAT must be 1 or 2");
    end
    if (RDW_MODE != "READ_FIRST" && RDW_MODE != "WRITE_FIRST" && RDW_MODE != "NO_CHANGE") begin : g_bad_rdw
        $error("bram_dp: unknown RDW_MODE");
    end

    // Array starts at zero from configuration; rst never clears it
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic              a_s1_valid_q, b_s1_valid_q;
    logic [DATA_W-1:0] a_s1_data_q,  b_s1_data_q;
    logic [DATA_W-1:0] a_s1_data_d,  b_s1_data_d;
    logic              a_load_c,     b_load_c;
    logic [DATA_W-1:0] a_word_c,     b_word_c;

    // Overlay the enabled bytes of new_w onto old_w
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     we
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Per-port read word and whether this access updates rdata
    always_comb begin
        a_load_c    = a_io.en && !(NC && (a_io.we != '0));
        b_load_c    = b_io.en && !(NC && (b_io.we != '0));
        a_word_c    = WF ? merge_bytes(mem_q[a_io.addr], a_io.wdata, a_io.we) : mem_q[a_io.addr];
        b_word_c    = WF ? merge_bytes(mem_q[b_io.addr], b_io.wdata, b_io.we) : mem_q[b_io.addr];
        a_s1_data_d = a_load_c ? a_word_c : a_s1_data_q;
        b_s1_data_d = b_load_c ? b_word_c : b_s1_data_q;
    end

    // Byte writes; port A is applied last so it wins overlapping bytes
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (b_io.en && b_io.we[i]) mem_q[b_io.addr][8*i +: 8] <= b_io.wdata[8*i +: 8];
                if (a_io.en && a_io.we[i]) mem_q[a_io.addr][8*i +: 8] <= a_io.wdata[8*i +: 8];
            end
        end
    end

    // Stage-1 read register and valid bit per port
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_valid_q <= 1'b0;
            b_s1_valid_q <= 1'b0;
            a_s1_data_q  <= '0;
            b_s1_data_q  <= '0;
        end else begin
            a_s1_valid_q <= a_load_c;
            b_s1_valid_q <= b_load_c;
            a_s1_data_q  <= a_s1_data_d;
            b_s1_data_q  <= b_s1_data_d;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              a_out_valid_q, b_out_valid_q;
        logic [DATA_W-1:0] a_out_data_q,  b_out_data_q;

        // Output register copies stage 1 every cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                a_out_valid_q <= 1'b0;
                b_out_valid_q <= 1'b0;
                a_out_data_q  <= '0;
                b_out_data_q  <= '0;
            end else begin
                a_out_valid_q <= a_s1_valid_q;
                b_out_valid_q <= b_s1_valid_q;
                a_out_data_q  <= a_s1_data_q;
                b_out_data_q  <= b_s1_data_q;
            end
        end

        assign a_io.rdata  = a_out_data_q;
        assign a_io.rvalid = a_out_valid_q;
        assign b_io.rdata  = b_out_data_q;
        assign b_io.rvalid = b_out_valid_q;
    end else begin : g_lat1
        assign a_io.rdata  = a_s1_data_q;
        assign a_io.rvalid = a_s1_valid_q;
        assign b_io.rdata  = b_s1_data_q;
        assign b_io.rvalid = b_s1_valid_q;
    end
endmodule

// File: tb/tb_bram_dp.sv
// Directed bench: three RAM configurations driven with identical stimulus.
// Index map: 0 rf.A, 1 rf.B (READ_FIRST, lat 1); 2 wf.A, 3 wf.B (WRITE_FIRST, lat 2);
// 4 nc.A, 5 nc.B (NO_CHANGE, lat 1).
module tb_bram_dp;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_port_if #(.DATA_W(32), .ADDR_W(10)) rf_a (), rf_b (), wf_a (), wf_b (), nc_a (), nc_b ();

    assign rf_a.en = a_en; assign rf_a.we = a_we; assign rf_a.addr = a_addr; assign rf_a.wdata = a_wdata;
    assign wf_a.en = a_en; assign wf_a.we = a_we; assign wf_a.addr = a_addr; assign wf_a.wdata = a_wdata;
    assign nc_a.en = a_en; assign nc_a.we = a_we; assign nc_a.addr = a_addr; assign nc_a.wdata = a_wdata;
    assign rf_b.en = b_en; assign rf_b.we = b_we; assign rf_b.addr = b_addr; assign rf_b.wdata = b_wdata;
    assign wf_b.en = b_en; assign wf_b.we = b_we; assign wf_b.addr = b_addr; assign wf_b.wdata = b_wdata;
    assign nc_b.en = b_en; assign nc_b.we = b_we; assign nc_b.addr = b_addr; assign nc_b.wdata = b_wdata;

    bram_dp #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .RDW_MODE("READ_FIRST"))
        u_rf (.clk(clk), .rst(rst), .a_io(rf_a), .b_io(rf_b));
    bram_dp #(.DATA_W(32), .ADDR_W(10), .READ_LAT(2), .RDW_MODE("WRITE_FIRST"))
        u_wf (.clk(clk), .rst(rst), .a_io(wf_a), .b_io(wf_b));
    bram_dp #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .RDW_MODE("NO_CHANGE"))
        u_nc (.clk(clk), .rst(rst), .a_io(nc_a), .b_io(nc_b));

    logic [31:0] rd [6];
    logic        rv [6];
    assign rd[0] = rf_a.rdata; assign rv[0] = rf_a.rvalid;
    assign rd[1] = rf_b.rdata; assign rv[1] = rf_b.rvalid;
    assign rd[2] = wf_a.rdata; assign rv[2] = wf_a.rvalid;
    assign rd[3] = wf_b.rdata; assign rv[3] = wf_b.rvalid;
    assign rd[4] = nc_a.rdata; assign rv[4] = nc_a.rvalid;
    assign rd[5] = nc_b.rdata; assign rv[5] = nc_b.rvalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check rdata and rvalid of output index p
    task automatic chk_port(input string tag, input int p, input logic [31:0] exp_rd, input logic exp_rv);
        chk({tag, "_rdata"}, rd[p], exp_rd);
        chk({tag, "_rvalid"}, 32'(rv[p]), 32'(exp_rv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wd);
        a_en = en; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic en, input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wd);
        b_en = en; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic idle();
        set_a(1'b0, 4'h0, 10'h0, 32'h0);
        set_b(1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    initial begin
        int pulses;

        // 1 Reset with both ports enabled and attempting writes to 0x003
        rst = 1'b1;
        set_a(1'b1, 4'hF, 10'h003, 32'hFFFF_FFFF);
        set_b(1'b1, 4'hF, 10'h003, 32'hEEEE_EEEE);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int p = 0; p < 6; p++) chk_port($sformatf("rst_c%0d_p%0d", c, p), p, 32'h0, 1'b0);
        end
        rst = 1'b0;
        idle();
        tick();
        for (int p = 0; p < 6; p++) chk_port($sformatf("post_rst_p%0d", p), p, 32'h0, 1'b0);

        // Writes during reset were suppressed: 0x003 still reads zero
        set_b(1'b1, 4'h0, 10'h003, 32'h0);
        tick();
        chk_port("rst_nowrite_rf_b", 1, 32'h0, 1'b1);
        idle();
        tick();
        tick();

        // 2 Byte write then read of 0x005
        set_a(1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF);
        tick();
        chk_port("bw_w1_rf_a", 0, 32'h0, 1'b1);
        chk_port("bw_w1_nc_a", 4, 32'h0, 1'b0);
        set_a(1'b1, 4'b0010, 10'h005, 32'h0000_AA00);
        tick();
        chk_port("bw_w2_rf_a", 0, 32'hDEAD_BEEF, 1'b1);
        chk_port("bw_w1_wf_a", 2, 32'hDEAD_BEEF, 1'b1);
        idle();
        tick();
        chk_port("bw_w2_wf_a", 2, 32'hDEAD_AAEF, 1'b1);
        tick();
        chk_port("bw_gap_wf_a", 2, 32'hDEAD_AAEF, 1'b0);
        set_a(1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        chk_port("bw_rd_rf_a", 0, 32'hDEAD_AAEF, 1'b1);
        chk_port("bw_rd_nc_a", 4, 32'hDEAD_AAEF, 1'b1);
        chk_port("bw_rd_wf_a_early", 2, 32'hDEAD_AAEF, 1'b0);
        idle();
        tick();
        chk_port("bw_rd_rf_a_hold", 0, 32'hDEAD_AAEF, 1'b0);
        chk_port("bw_rd_wf_a", 2, 32'hDEAD_AAEF, 1'b1);
        tick();
        chk_port("bw_rd_wf_a_after", 2, 32'hDEAD_AAEF, 1'b0);

        // 3 Read-during-write modes on 0x010
        set_a(1'b1, 4'hF, 10'h010, 32'h1111_1111);
        tick();
        idle();
        tick();
        tick();
        set_a(1'b1, 4'hF, 10'h010, 32'h2222_2222);
        tick();
        chk_port("rdw_rf_a", 0, 32'h1111_1111, 1'b1);
        chk_port("rdw_nc_a", 4, 32'hDEAD_AAEF, 1'b0);
        idle();
        tick();
        chk_port("rdw_wf_a", 2, 32'h2222_2222, 1'b1);
        chk_port("rdw_nc_a_hold", 4, 32'hDEAD_AAEF, 1'b0);
        tick();

        // 4 Same-cycle collisions at the top address 0x3FF
        set_a(1'b1, 4'hF, 10'h3FF, 32'hAAAA_AAAA);
        set_b(1'b1, 4'hF, 10'h3FF, 32'hBBBB_BBBB);
        tick();
        idle();
        tick();
        set_b(1'b1, 4'h0, 10'h3FF, 32'h0);
        tick();
        chk_port("col_full_rf_b", 1, 32'hAAAA_AAAA, 1'b1);
        chk_port("col_full_nc_b", 5, 32'hAAAA_AAAA, 1'b1);
        idle();
        tick();
        chk_port("col_full_wf_b", 3, 32'hAAAA_AAAA, 1'b1);
        set_a(1'b1, 4'b0011, 10'h3FF, 32'h5555_5555);
        set_b(1'b1, 4'b1100, 10'h3FF, 32'hBBBB_BBBB);
        tick();
        set_a(1'b1, 4'b0011, 10'h3FF, 32'hAAAA_AAAA);
        set_b(1'b1, 4'b1100, 10'h3FF, 32'hCCCC_CCCC);
        tick();
        idle();
        tick();
        set_b(1'b1, 4'h0, 10'h3FF, 32'h0);
        tick();
        chk_port("col_split_rf_b", 1, 32'hCCCC_AAAA, 1'b1);
        set_a(1'b1, 4'b0011, 10'h3FF, 32'hAAAA_AAAA);
        set_b(1'b1, 4'b1100, 10'h3FF, 32'hBBBB_BBBB);
        tick();
        idle();
        tick();
        set_b(1'b1, 4'h0, 10'h3FF, 32'h0);
        tick();
        chk_port("col_spec_rf_b", 1, 32'hBBBB_AAAA, 1'b1);
        idle();
        tick();
        chk_port("col_spec_wf_b", 3, 32'hBBBB_AAAA, 1'b1);

        // 5 Cross-port read of a word being written by the other port
        set_a(1'b1, 4'hF, 10'h020, 32'h0000_0001);
        tick();
        idle();
        tick();
        set_a(1'b1, 4'hF, 10'h020, 32'h0000_0002);
        set_b(1'b1, 4'h0, 10'h020, 32'h0);
        tick();
        chk_port("xp_old_rf_b", 1, 32'h0000_0001, 1'b1);
        chk_port("xp_old_nc_b", 5, 32'h0000_0001, 1'b1);
        set_a(1'b0, 4'h0, 10'h0, 32'h0);
        tick();
        chk_port("xp_new_rf_b", 1, 32'h0000_0002, 1'b1);
        chk_port("xp_old_wf_b", 3, 32'h0000_0001, 1'b1);
        idle();
        tick();
        chk_port("xp_new_wf_b", 3, 32'h0000_0002, 1'b1);

        // 6 Prefill 0..15, then stream reads on port B
        for (int k = 0; k < 16; k++) begin
            set_a(1'b1, 4'hF, 10'(k), 32'hC0DE_0000 | 32'(k));
            tick();
        end
        idle();
        tick();
        tick();
        pulses = 0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) set_b(1'b1, 4'h0, 10'(k), 32'h0);
            else        idle();
            tick();
            if (k < 16) chk_port($sformatf("strm_rf_b_%0d", k), 1, 32'hC0DE_0000 | 32'(k), 1'b1);
            if (k >= 1 && k <= 16) begin
                chk_port($sformatf("strm_wf_b_%0d", k - 1), 3, 32'hC0DE_0000 | 32'(k - 1), 1'b1);
            end else begin
                chk($sformatf("strm_wf_b_quiet_%0d", k), 32'(rv[3]), 32'h0);
            end
            if (rv[3]) pulses++;
        end
        chk("strm_pulse_count", 32'(pulses), 32'd16);

        // Stream again, asserting rst at read 8; read 7 must be flushed
        for (int k = 0; k < 8; k++) begin
            set_b(1'b1, 4'h0, 10'(k), 32'h0);
            tick();
            if (k >= 1) chk_port($sformatf("strm2_wf_b_%0d", k - 1), 3, 32'hC0DE_0000 | 32'(k - 1), 1'b1);
        end
        rst = 1'b1;
        for (int k = 8; k < 11; k++) begin
            set_b(1'b1, 4'h0, 10'(k), 32'h0);
            tick();
            chk_port($sformatf("strm2_rst_wf_b_%0d", k), 3, 32'h0, 1'b0);
            chk_port($sformatf("strm2_rst_rf_b_%0d", k), 1, 32'h0, 1'b0);
        end
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_port($sformatf("strm2_after_wf_b_%0d", k), 3, 32'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
